mem_stage: RTL and testbench

//  Memory-access stage directly downstream of the ALU. Consumes the ALU result

---
 rtl/mem_stage_if.sv | 42 ++++
 rtl/mem_stage.sv | 109 ++++++++++
 tb/tb_mem_stage.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bundles the upstream record, data-memory bus and writeback record of mem_stage.
// The slave modport is the stage's view; master is the surrounding pipeline/memory.
interface mem_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_valE;
   logic [31:0] in_valB;
   logic [4:0]  in_dst;

   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_dst;
   logic        out_wen;
   logic        out_err;

   modport slave (
      input  in_valid, in_op, in_valE, in_valB, in_dst,
      output in_ready,
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_ack, dm_rdata,
      output out_valid, out_data, out_dst, out_wen, out_err,
      input  out_ready
   );

   modport master (
      output in_valid, in_op, in_valE, in_valB, in_dst,
      input  in_ready,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_ack, dm_rdata,
      input  out_valid, out_data, out_dst, out_wen, out_err,
      output out_ready
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU pass-through or LW/SW over a req/ack bus with
// timeout, producing one registered writeback record per accepted input.
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic       clk,
   input  logic       rst,
   mem_stage_if.slave bus,
   output logic       dbg_state
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] OP_ALU = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          pend_lw;
   logic [4:0]    pend_dst;
   logic          accept;
   logic          is_mem;
   logic          misaligned;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
   // the producer holds its payload stable while valid=1 and ready=0.
   assign bus.in_ready = !rst && (state == IDLE) && (!bus.out_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign is_mem       = (bus.in_op == OP_LW) || (bus.in_op == OP_SW);
   assign misaligned   = (bus.in_valE[1:0] != 2'b00);
   assign dbg_state    = (state == ACCESS);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         pend_lw      <= 1'b0;
         pend_dst     <= 5'd0;
         bus.dm_req   <= 1'b0;
         bus.dm_we    <= 1'b0;
         bus.dm_addr  <= 32'd0;
         bus.dm_wdata <= 32'd0;
         bus.out_valid <= 1'b0;
         bus.out_data <= 32'd0;
         bus.out_dst  <= 5'd0;
         bus.out_wen  <= 1'b0;
         bus.out_err  <= 1'b0;
      end else begin
         if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (accept) begin
                  pend_dst <= bus.in_dst;
                  if (is_mem && !misaligned) begin
                     state        <= ACCESS;
                     wait_cnt     <= '0;
                     pend_lw      <= (bus.in_op == OP_LW);
                     bus.dm_req   <= 1'b1;
                     bus.dm_we    <= (bus.in_op == OP_SW);
                     bus.dm_addr  <= bus.in_valE;
                     bus.dm_wdata <= bus.in_valB;
                  end else begin
                     // Pass-through and immediate errors both complete in one cycle.
                     bus.out_valid <= 1'b1;
                     bus.out_dst   <= bus.in_dst;
                     if (bus.in_op == OP_ALU) begin
                        bus.out_data <= bus.in_valE;
                        bus.out_wen  <= (bus.in_dst != 5'd0);
                        bus.out_err  <= 1'b0;
                     end else begin
                        bus.out_data <= 32'd0;
                        bus.out_wen  <= 1'b0;
                        bus.out_err  <= 1'b1;
                     end
                  end
               end
            end

            ACCESS: begin
               // An ack on the final allowed cycle still completes normally.
               if (bus.dm_ack) begin
                  state         <= IDLE;
                  bus.dm_req    <= 1'b0;
                  bus.out_valid <= 1'b1;
                  bus.out_dst   <= pend_dst;
                  bus.out_data  <= pend_lw ? bus.dm_rdata : 32'd0;
                  bus.out_wen   <= pend_lw && (pend_dst != 5'd0);
                  bus.out_err   <= 1'b0;
               end else if (wait_cnt == LAST_WAIT) begin
                  state         <= IDLE;
                  bus.dm_req    <= 1'b0;
                  bus.out_valid <= 1'b1;
                  bus.out_dst   <= pend_dst;
                  bus.out_data  <= 32'd0;
                  bus.out_wen   <= 1'b0;
                  bus.out_err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model with a per-cycle compare process,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_stage;
   localparam int TIMEOUT = 15;
   localparam int W = 39;  // {data[31:0], dst[4:0], wen, err}

   logic clk;
   logic rst;
   logic dbg_state;
   mem_stage_if bus();

   mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int req_run = 0;
   int last_req_len = 0;
   int req_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // request-run monitor, sampled with pre-edge values
   always @(posedge clk) begin
      cyc++;
      if (bus.dm_req === 1'b1) begin
         req_run++;
         req_total++;
         last_req_len = req_run;
      end else begin
         req_run = 0;
      end
   end

   // scoreboard model
   logic [W-1:0] exp_q[$];
   logic [W-1:0] rec;
   bit           m_busy = 0;
   bit           m_lw = 0;
   bit           m_we = 0;
   logic [4:0]   m_dst = '0;
   logic [31:0]  m_addr = '0;
   logic [31:0]  m_wdata = '0;
   int           m_wait = 0;
   bit           exp_ready;

   always @(negedge clk) begin
      exp_ready = !rst && !m_busy && (exp_q.size() == 0 || bus.out_ready);
      chk("in_ready", bus.in_ready, exp_ready);
      chk("dm_req", bus.dm_req, m_busy);
      chk("dbg_state", dbg_state, m_busy);
      if (m_busy) begin
         chk("dm_addr", bus.dm_addr, m_addr);
         chk("dm_we", bus.dm_we, m_we);
         chk("dm_wdata", bus.dm_wdata, m_wdata);
      end
      chk("out_valid", bus.out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         rec = exp_q[0];
         chk("out_data", bus.out_data, rec[38:7]);
         chk("out_dst", bus.out_dst, rec[6:2]);
         chk("out_wen", bus.out_wen, rec[1]);
         chk("out_err", bus.out_err, rec[0]);
      end

      // advance the model across the coming rising edge
      if (rst) begin
         exp_q.delete();
         m_busy = 0;
      end else begin
         if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
         if (m_busy) begin
            if (bus.dm_ack) begin
               exp_q.push_back({m_lw ? bus.dm_rdata : 32'h0, m_dst, m_lw && (m_dst != 0), 1'b0});
               m_busy = 0;
            end else begin
               m_wait++;
               if (m_wait == TIMEOUT) begin
                  exp_q.push_back({32'h0, m_dst, 1'b0, 1'b1});
                  m_busy = 0;
               end
            end
         end else if (bus.in_valid && exp_ready) begin
            if (bus.in_op == 2'b00)
               exp_q.push_back({bus.in_valE, bus.in_dst, bus.in_dst != 0, 1'b0});
            else if (bus.in_op == 2'b11 || bus.in_valE[1:0] != 2'b00)
               exp_q.push_back({32'h0, bus.in_dst, 1'b0, 1'b1});
            else begin
               m_busy  = 1;
               m_wait  = 0;
               m_lw    = (bus.in_op == 2'b01);
               m_we    = (bus.in_op == 2'b10);
               m_dst   = bus.in_dst;
               m_addr  = bus.in_valE;
               m_wdata = bus.in_valB;
            end
         end
      end
   end

   // driver tasks; all inputs change 1 time unit after a rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [31:0] ve, input logic [31:0] vb,
                        input logic [4:0] dst);
      bit ok;
      ok = 0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_valE  = ve;
      bus.in_valB  = vb;
      bus.in_dst   = dst;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = bus.in_ready;
         step();
      end
      bus.in_valid = 1'b0;
      chk("accepted", ok, 1'b1);
   endtask

   task automatic mem_respond(input int n, input logic [31:0] rd, input logic e_we,
                              input logic [31:0] e_addr, input logic [31:0] e_wd);
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = bus.dm_req;
      end
      chk("req_seen", seen, 1'b1);
      chk("req_addr_lit", bus.dm_addr, e_addr);
      chk("req_we_lit", bus.dm_we, e_we);
      chk("req_wdata_lit", bus.dm_wdata, e_wd);
      repeat (n - 1) step();
      bus.dm_ack   = 1'b1;
      bus.dm_rdata = rd;
      step();
      bus.dm_ack   = 1'b0;
      bus.dm_rdata = $urandom;
   endtask

   int c0;
   int tot0;
   bit got;

   initial begin
      rst = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_op     = 2'b00;
      bus.in_valE   = 32'h55;
      bus.in_valB   = 32'h0;
      bus.in_dst    = 5'd1;
      bus.dm_ack    = 1'b1;
      bus.dm_rdata  = 32'h0;
      bus.out_ready = 1'b1;

      // reset with traffic present: nothing accepted, outputs zero
      repeat (3) begin
         @(negedge clk);
         chk("rst_in_ready", bus.in_ready, 1'b0);
         chk("rst_out_valid", bus.out_valid, 1'b0);
         chk("rst_dm_req", bus.dm_req, 1'b0);
         chk("rst_out_data", bus.out_data, 32'h0);
         chk("rst_dm_addr", bus.dm_addr, 32'h0);
      end
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.dm_ack = 1'b0;
      @(negedge clk);
      chk("post_rst_out_valid", bus.out_valid, 1'b0);
      step();

      // pass-through, then three back-to-back
      drive(2'b00, 32'h12, 32'h0, 5'd3);
      @(negedge clk);
      chk("pt_valid", bus.out_valid, 1'b1);
      chk("pt_data", bus.out_data, 32'h12);
      chk("pt_wen", bus.out_wen, 1'b1);
      chk("pt_err", bus.out_err, 1'b0);
      step();
      c0 = cyc;
      drive(2'b00, 32'hA1, 32'h0, 5'd4);
      drive(2'b00, 32'hA2, 32'h0, 5'd0);
      drive(2'b00, 32'hA3, 32'h0, 5'd6);
      chk("b2b_cycles", cyc - c0, 3);
      @(negedge clk);
      chk("b2b_last_data", bus.out_data, 32'hA3);
      step();

      // LW with ack after 3 request cycles
      fork
         drive(2'b01, 32'h100, 32'h0, 5'd5);
         mem_respond(3, 32'hDEADBEEF, 1'b0, 32'h100, 32'h0);
      join
      @(negedge clk);
      chk("lw_req_len", last_req_len, 3);
      chk("lw_data", bus.out_data, 32'hDEADBEEF);
      chk("lw_wen", bus.out_wen, 1'b1);
      step();

      // SW
      fork
         drive(2'b10, 32'h104, 32'h0000A5A5, 5'd7);
         mem_respond(2, 32'h31415926, 1'b1, 32'h104, 32'h0000A5A5);
      join
      @(negedge clk);
      chk("sw_valid", bus.out_valid, 1'b1);
      chk("sw_wen", bus.out_wen, 1'b0);
      chk("sw_err", bus.out_err, 1'b0);
      chk("sw_data", bus.out_data, 32'h0);
      step();

      // immediate errors: misaligned LW, reserved op
      tot0 = req_total;
      drive(2'b01, 32'h102, 32'h0, 5'd4);
      @(negedge clk);
      chk("mis_err", bus.out_err, 1'b1);
      chk("mis_data", bus.out_data, 32'h0);
      chk("mis_wen", bus.out_wen, 1'b0);
      step();
      drive(2'b11, 32'h200, 32'h0, 5'd8);
      @(negedge clk);
      chk("rsv_err", bus.out_err, 1'b1);
      chk("rsv_data", bus.out_data, 32'h0);
      chk("rsv_wen", bus.out_wen, 1'b0);
      step();
      chk("err_no_req", req_total - tot0, 0);

      // LW timeout
      drive(2'b01, 32'h300, 32'h0, 5'd9);
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = bus.out_valid;
      end
      chk("to_seen", got, 1'b1);
      chk("to_req_len", last_req_len, TIMEOUT);
      chk("to_err", bus.out_err, 1'b1);
      chk("to_wen", bus.out_wen, 1'b0);
      chk("to_data", bus.out_data, 32'h0);
      step();

      // ack on the last allowed cycle wins
      fork
         drive(2'b01, 32'h304, 32'h0, 5'd10);
         mem_respond(TIMEOUT, 32'h13572468, 1'b0, 32'h304, 32'h0);
      join
      @(negedge clk);
      chk("late_req_len", last_req_len, TIMEOUT);
      chk("late_err", bus.out_err, 1'b0);
      chk("late_data", bus.out_data, 32'h13572468);
      step();

      // reset mid-access
      drive(2'b01, 32'h400, 32'h0, 5'd11);
      @(negedge clk);
      chk("mid_req_on", bus.dm_req, 1'b1);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_req_on_rst", bus.dm_req, 1'b1);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_req_off", bus.dm_req, 1'b0);
      chk("mid_out_valid", bus.out_valid, 1'b0);
      step();

      // downstream stall holds the record and blocks upstream
      bus.out_ready = 1'b0;
      drive(2'b00, 32'h77, 32'h0, 5'd9);
      bus.in_valid = 1'b1;
      bus.in_op    = 2'b00;
      bus.in_valE  = 32'h88;
      bus.in_dst   = 5'd10;
      repeat (4) begin
         @(negedge clk);
         chk("stall_data", bus.out_data, 32'h77);
         chk("stall_dst", bus.out_dst, 5'd9);
         chk("stall_in_ready", bus.in_ready, 1'b0);
      end
      step();
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("drain_in_ready", bus.in_ready, 1'b1);
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("drain_next_data", bus.out_data, 32'h88);
      step();
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
